sram_port_requester: RTL and testbench

//  Initiator side of the generic SRAM macro port (A1/CSB1/WEB1/WBM1/I1/OEB1/O1).

---
 rtl/sram_ctrl_pkg.sv | 7 +
 rtl/sram_resp_queue.sv | 57 +++++
 rtl/sram_port_requester.sv | 122 ++++++++++++
 tb/tb_sram_port_requester.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared encodings for the SRAM port requester and its response queue.
package sram_ctrl_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/sram_resp_queue.sv
// Circular response FIFO with a same-cycle bypass when empty.
// Overflow is prevented upstream by throttling requests against the count output.
module sram_resp_queue #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_val,
  input  logic [W-1:0]  in_data,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          enq;
  logic          deq;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign out_val  = ~reset & (empty ? in_val : 1'b1);
  assign out_data = empty ? in_data : mem[rd_ptr];
  assign deq      = ~empty & out_rdy;
  // A bypassed response that is consumed immediately never occupies an entry.
  assign enq      = in_val & ~(empty & out_rdy);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= bump(wr_ptr);
      if (deq) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // NOTE: entry storage is deliberately not reset; count alone decides which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/sram_port_requester.sv
// Drives one generic SRAM port from a val/rdy request stream and returns one
// in-order response per request, absorbing the 1-cycle read latency.
module sram_port_requester
  import sram_ctrl_pkg::*;
#(
  parameter  int num_bits    = 128,
  parameter  int num_words   = 256,
  parameter  int OPAQUE_BITS = 8,
  parameter  int RESP_DEPTH  = 2,
  localparam int AW          = $clog2(num_words)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_type,
  input  logic [AW-1:0]          req_addr,
  input  logic [num_bits-1:0]    req_data,
  input  logic [num_bits/8-1:0]  req_bmask,
  input  logic [OPAQUE_BITS-1:0] req_opaque,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_type,
  output logic [num_bits-1:0]    resp_data,
  output logic [OPAQUE_BITS-1:0] resp_opaque,
  output logic [AW-1:0]          A1,
  output logic                   CE1,
  output logic                   CSB1,
  output logic                   WEB1,
  output logic [num_bits-1:0]    WBM1,
  output logic [num_bits-1:0]    I1,
  output logic                   OEB1,
  input  logic [num_bits-1:0]    O1
);

  localparam int NB = num_bits / 8;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(RESP_DEPTH);

  typedef struct packed {
    logic                   typ;
    logic [OPAQUE_BITS-1:0] opaque;
    logic [num_bits-1:0]    data;
  } resp_t;

  logic                   fire;
  logic                   inflight_val;
  logic                   inflight_type;
  logic [OPAQUE_BITS-1:0] inflight_opaque;
  logic [CW-1:0]          q_count;
  logic [CW:0]            pending;
  logic [num_bits-1:0]    wbm_full;
  resp_t                  in_resp;
  resp_t                  out_resp;

  // Throttle on registered state only, so no combinational path from resp_rdy.
  assign pending = {1'b0, q_count} + {{CW{1'b0}}, inflight_val};
  assign req_rdy = ~reset & (pending < DEPTH_LIM);
  assign fire    = req_val & req_rdy;

  for (genvar j = 0; j < NB; j++) begin : g_bmask
    assign wbm_full[8*j +: 8] = {8{req_bmask[j]}};
  end

  // NOTE: every output gets a default before the branch, which keeps this
  // block purely combinational with no inferred latches.
  always_comb begin
    A1   = '0;
    I1   = '0;
    WBM1 = '0;
    CSB1 = 1'b1;
    WEB1 = 1'b1;
    if (fire) begin
      CSB1 = 1'b0;
      A1   = req_addr;
      I1   = req_data;
      WEB1 = ~req_type;
      if (req_type == MEM_WRITE) WBM1 = wbm_full;
    end
  end

  assign CE1 = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_val    <= 1'b0;
      inflight_type   <= MEM_READ;
      inflight_opaque <= '0;
    end else begin
      inflight_val    <= fire;
      inflight_type   <= req_type;
      inflight_opaque <= req_opaque;
    end
  end

  assign OEB1 = ~(inflight_val & (inflight_type == MEM_READ));

  always_comb begin
    in_resp.typ    = inflight_type;
    in_resp.opaque = inflight_opaque;
    in_resp.data   = (inflight_type == MEM_READ) ? O1 : '0;
  end

  sram_resp_queue #(
    .W     ($bits(resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_queue (
    .clk      (clk),
    .reset    (reset),
    .in_val   (inflight_val),
    .in_data  (in_resp),
    .out_val  (resp_val),
    .out_rdy  (resp_rdy),
    .out_data (out_resp),
    .count    (q_count)
  );

  assign resp_type   = out_resp.typ;
  assign resp_opaque = out_resp.opaque;
  assign resp_data   = out_resp.data;

endmodule

// File: tb/tb_sram_port_requester.sv
// Directed bench for sram_port_requester: default 128x256 build plus a 32x64 build,
// each wired to a behavioural 1-cycle-latency SRAM.
module tb_sram_port_requester;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  localparam logic [127:0] DB    = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
  localparam logic [127:0] DB_AA = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEAA;

  logic clk;
  logic reset;

  logic         req_val, req_rdy, req_type, resp_val, resp_rdy, resp_type;
  logic [7:0]   req_addr, req_opaque, resp_opaque, A1;
  logic [127:0] req_data, resp_data, WBM1, I1, O1;
  logic [15:0]  req_bmask;
  logic         CE1, CSB1, WEB1, OEB1;

  logic         n_req_val, n_req_rdy, n_req_type, n_resp_val, n_resp_rdy, n_resp_type;
  logic [5:0]   n_req_addr, n_A1;
  logic [7:0]   n_req_opaque, n_resp_opaque;
  logic [31:0]  n_req_data, n_resp_data, n_WBM1, n_I1, n_O1;
  logic [3:0]   n_req_bmask;
  logic         n_CE1, n_CSB1, n_WEB1, n_OEB1;

  int n_checks = 0;
  int n_fail   = 0;
  int fires;

  sram_port_requester dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type), .req_addr(req_addr),
    .req_data(req_data), .req_bmask(req_bmask), .req_opaque(req_opaque),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type),
    .resp_data(resp_data), .resp_opaque(resp_opaque),
    .A1(A1), .CE1(CE1), .CSB1(CSB1), .WEB1(WEB1), .WBM1(WBM1), .I1(I1),
    .OEB1(OEB1), .O1(O1)
  );

  sram_port_requester #(.num_bits(32), .num_words(64)) dut_n (
    .clk(clk), .reset(reset),
    .req_val(n_req_val), .req_rdy(n_req_rdy), .req_type(n_req_type), .req_addr(n_req_addr),
    .req_data(n_req_data), .req_bmask(n_req_bmask), .req_opaque(n_req_opaque),
    .resp_val(n_resp_val), .resp_rdy(n_resp_rdy), .resp_type(n_resp_type),
    .resp_data(n_resp_data), .resp_opaque(n_resp_opaque),
    .A1(n_A1), .CE1(n_CE1), .CSB1(n_CSB1), .WEB1(n_WEB1), .WBM1(n_WBM1), .I1(n_I1),
    .OEB1(n_OEB1), .O1(n_O1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unwritten words read back as a known address-derived pattern.
  function automatic logic [127:0] init_word(input int i);
    return {96'h0, 32'hC0DE_0000 + 32'(i)};
  endfunction

  logic [127:0] mem [256];
  bit   [255:0] seen;
  always @(posedge clk) begin
    if (!CSB1) begin
      if (!WEB1) begin
        mem[A1]  <= ((seen[A1] ? mem[A1] : init_word(int'(A1))) & ~WBM1) | (I1 & WBM1);
        seen[A1] <= 1'b1;
      end else begin
        O1 <= seen[A1] ? mem[A1] : init_word(int'(A1));
      end
    end
  end

  logic [31:0] n_mem [64];
  always @(posedge clk) begin
    if (!n_CSB1) begin
      if (!n_WEB1) n_mem[n_A1] <= (n_mem[n_A1] & ~n_WBM1) | (n_I1 & n_WBM1);
      else         n_O1 <= n_mem[n_A1];
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic typ, input logic [7:0] addr, input logic [127:0] data,
                       input logic [15:0] bmask, input logic [7:0] tag);
    req_val = 1'b1; req_type = typ; req_addr = addr;
    req_data = data; req_bmask = bmask; req_opaque = tag;
  endtask

  task automatic idle();
    req_val = 1'b0; req_type = RD; req_addr = '0;
    req_data = '0; req_bmask = '0; req_opaque = '0;
  endtask

  task automatic n_drive(input logic typ, input logic [5:0] addr, input logic [31:0] data,
                         input logic [3:0] bmask, input logic [7:0] tag);
    n_req_val = 1'b1; n_req_type = typ; n_req_addr = addr;
    n_req_data = data; n_req_bmask = bmask; n_req_opaque = tag;
  endtask

  task automatic n_idle();
    n_req_val = 1'b0; n_req_type = RD; n_req_addr = '0;
    n_req_data = '0; n_req_bmask = '0; n_req_opaque = '0;
  endtask

  initial begin
    reset = 1'b1;
    resp_rdy = 1'b1;
    n_resp_rdy = 1'b1;
    idle();
    n_idle();
    repeat (2) @(posedge clk);

    // Reset state
    sample();
    check("rst_req_rdy", req_rdy, 0);
    check("rst_resp_val", resp_val, 0);
    check("rst_csb", CSB1, 1);
    check("rst_web", WEB1, 1);
    check("rst_oeb", OEB1, 1);
    check("rst_ce", CE1, 1);
    check("rst_a1", A1, 0);
    check("rst_i1", I1, 0);
    check("rst_wbm", WBM1, 0);
    cyc();
    reset = 1'b0;
    sample();
    check("idle_req_rdy", req_rdy, 1);
    check("idle_csb", CSB1, 1);

    // Full write then read of addr 5
    cyc(); drive(WR, 8'd5, DB, 16'hFFFF, 8'h11);
    sample();
    check("wr_csb", CSB1, 0);
    check("wr_web", WEB1, 0);
    check("wr_a1", A1, 5);
    check("wr_wbm", WBM1, {128{1'b1}});
    check("wr_i1", I1, DB);
    check("wr_resp_val", resp_val, 0);
    cyc(); drive(RD, 8'd5, '0, 16'hFFFF, 8'h22);
    sample();
    check("wr_resp_val1", resp_val, 1);
    check("wr_resp_type", resp_type, WR);
    check("wr_resp_data", resp_data, 0);
    check("wr_resp_tag", resp_opaque, 8'h11);
    check("rd_web", WEB1, 1);
    check("rd_wbm", WBM1, 0);
    check("rd_oeb_wr", OEB1, 1);
    cyc(); idle();
    sample();
    check("rd_resp_val", resp_val, 1);
    check("rd_resp_type", resp_type, RD);
    check("rd_resp_data", resp_data, DB);
    check("rd_resp_tag", resp_opaque, 8'h22);
    check("rd_oeb", OEB1, 0);
    cyc();
    sample();
    check("quiet_resp_val", resp_val, 0);
    check("quiet_oeb", OEB1, 1);

    // Partial write of byte 0
    cyc(); drive(WR, 8'd5, 128'hAA, 16'h0001, 8'h33);
    sample();
    check("pw_wbm", WBM1, 128'hFF);
    cyc(); drive(RD, 8'd5, '0, '0, 8'h44);
    sample();
    check("pw_resp_tag", resp_opaque, 8'h33);
    cyc(); idle();
    sample();
    check("pw_rd_data", resp_data, DB_AA);
    check("pw_rd_tag", resp_opaque, 8'h44);

    // Stream of 8 reads at full rate
    for (int k = 0; k <= 8; k++) begin
      cyc();
      if (k < 8) drive(RD, 8'(10 + k), '0, '0, 8'(k));
      else idle();
      sample();
      if (k < 8) check($sformatf("str_rdy%0d", k), req_rdy, 1);
      if (k >= 1) begin
        check($sformatf("str_val%0d", k - 1), resp_val, 1);
        check($sformatf("str_tag%0d", k - 1), resp_opaque, 128'(k - 1));
        check($sformatf("str_data%0d", k - 1), resp_data, init_word(10 + k - 1));
      end
    end
    cyc();
    sample();
    check("str_done", resp_val, 0);

    // Backpressure: only RESP_DEPTH requests accepted
    resp_rdy = 1'b0;
    fires = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      drive(RD, 8'(20 + fires), '0, '0, 8'(8'h40 + fires));
      sample();
      if (req_val && req_rdy) fires++;
    end
    check("bp_fires", 128'(fires), 2);
    check("bp_rdy", req_rdy, 0);
    check("bp_head_val", resp_val, 1);
    check("bp_head_tag", resp_opaque, 8'h40);
    cyc(); idle(); resp_rdy = 1'b1;
    sample();
    check("drain0_val", resp_val, 1);
    check("drain0_tag", resp_opaque, 8'h40);
    check("drain0_data", resp_data, init_word(20));
    cyc();
    sample();
    check("drain1_val", resp_val, 1);
    check("drain1_tag", resp_opaque, 8'h41);
    check("drain1_data", resp_data, init_word(21));
    cyc();
    sample();
    check("drain_empty", resp_val, 0);
    check("drain_rdy", req_rdy, 1);

    // Reset with one queued and one in flight
    resp_rdy = 1'b0;
    cyc(); drive(RD, 8'd30, '0, '0, 8'h50);
    sample();
    check("mr_fire0", req_rdy, 1);
    cyc(); drive(RD, 8'd31, '0, '0, 8'h51);
    sample();
    check("mr_fire1", req_rdy, 1);
    cyc(); idle(); reset = 1'b1;
    sample();
    check("mr_in_val", resp_val, 0);
    check("mr_in_csb", CSB1, 1);
    cyc(); reset = 1'b0; resp_rdy = 1'b1;
    sample();
    check("mr_resp_val", resp_val, 0);
    check("mr_csb", CSB1, 1);
    check("mr_oeb", OEB1, 1);
    check("mr_rdy", req_rdy, 1);
    cyc();
    sample();
    check("mr_no_ghost", resp_val, 0);
    cyc(); drive(RD, 8'd5, '0, '0, 8'h60);
    sample();
    cyc(); idle();
    sample();
    check("mr_rd_val", resp_val, 1);
    check("mr_rd_data", resp_data, DB_AA);
    check("mr_rd_tag", resp_opaque, 8'h60);

    // 32-bit x 64-word build, top address
    cyc(); n_drive(WR, 6'd63, 32'hDEAD_BEEF, 4'hF, 8'h70);
    sample();
    check("n_rdy", n_req_rdy, 1);
    check("n_a1", n_A1, 63);
    check("n_wbm_full", n_WBM1, 32'hFFFF_FFFF);
    cyc(); n_drive(WR, 6'd63, 32'h1122_3344, 4'b0101, 8'h71);
    sample();
    check("n_wbm_part", n_WBM1, 32'h00FF_00FF);
    check("n_wr_type", n_resp_type, WR);
    check("n_wr_data", n_resp_data, 0);
    check("n_wr_tag", n_resp_opaque, 8'h70);
    cyc(); n_drive(RD, 6'd63, '0, 4'hF, 8'h72);
    sample();
    check("n_rd_wbm", n_WBM1, 0);
    check("n_wr2_tag", n_resp_opaque, 8'h71);
    cyc(); n_idle();
    sample();
    check("n_rd_val", n_resp_val, 1);
    check("n_rd_type", n_resp_type, RD);
    check("n_rd_data", n_resp_data, 32'hDE22_BE44);
    check("n_rd_tag", n_resp_opaque, 8'h72);
    cyc();
    sample();
    check("n_done", n_resp_val, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
